// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions used by the capture, buffering and readout blocks.
`timescale 1ns/1ps
package la_pkg;

    localparam int SAMPLE_W_DEFAULT   = 8;
    localparam int FIFO_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/sample_fifo_if.sv
// Sample buffer handshake and status bundle; the producer/reader side drives master, the buffer is slave.
`timescale 1ns/1ps
interface sample_fifo_if
    import la_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W_DEFAULT,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
);

    localparam int AW = $clog2(DEPTH);

    logic             clr;
    logic             ring_mode;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic [AW:0]      count;
    logic             overflow;

    modport master (
        output clr, ring_mode, wr_en, wr_data, rd_en,
        input  wr_ready, rd_data, rd_valid, full, empty, count, overflow
    );

    modport slave (
        input  clr, ring_mode, wr_en, wr_data, rd_en,
        output wr_ready, rd_data, rd_valid, full, empty, count, overflow
    );

endinterface

// File: rtl/sample_fifo_mem.sv
// Simple dual-port sample array with synchronous write and a registered read port.
`timescale 1ns/1ps
module sample_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

    // Storage array; never reset so flushes leave old contents in place.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register; a read of the slot being written this cycle returns the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/sample_fifo.sv
// Circular sample buffer with drop-or-overwrite full policy, registered read port and sticky overflow.
`timescale 1ns/1ps
module sample_fifo
    import la_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W_DEFAULT,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    sample_fifo_if.slave bus
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1'b1);

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nxt_s;
    logic          full_r;
    logic          empty_r;
    logic          overflow_r;
    logic          rd_valid_r;

    logic          rd_accept_s;
    logic          wr_accept_s;
    logic          overwrite_s;
    logic          drop_s;
    logic          rd_adv_s;
    logic          mem_we_s;
    logic          mem_re_s;

    assign rd_accept_s = bus.rd_en & ~empty_r;
    assign wr_accept_s = bus.wr_en & (~full_r | rd_accept_s | bus.ring_mode);
    // Ring-mode write into a full buffer with no read pushes the oldest sample out.
    assign overwrite_s = wr_accept_s & full_r & ~rd_accept_s;
    assign drop_s      = bus.wr_en & ~wr_accept_s;
    assign rd_adv_s    = rd_accept_s | overwrite_s;
    assign mem_we_s    = wr_accept_s & ~bus.clr;
    assign mem_re_s    = rd_accept_s & ~bus.clr;

    // Single occupancy update covering write-only, read-only, both and neither.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_accept_s, rd_accept_s})
            2'b10: begin
                if (!full_r) begin
                    count_nxt_s = count_r + CNT_ONE;
                end else begin
                    count_nxt_s = count_r;
                end
            end
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy, flags and read-valid pulse; clr flushes everything but memory and rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
            rd_valid_r <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (rd_adv_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            if (drop_s | overwrite_s) begin
                overflow_r <= 1'b1;
            end
            count_r    <= count_nxt_s;
            full_r     <= (count_nxt_s == CNT_MAX);
            empty_r    <= (count_nxt_s == {(AW+1){1'b0}});
            rd_valid_r <= rd_accept_s;
        end
    end

    sample_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (mem_we_s),
        .wr_addr (wr_ptr_r),
        .wr_data (bus.wr_data),
        .rd_en   (mem_re_s),
        .rd_addr (rd_ptr_r),
        .rd_data (bus.rd_data)
    );

    assign bus.wr_ready = ~full_r | bus.ring_mode;
    assign bus.rd_valid = rd_valid_r;
    assign bus.full     = full_r;
    assign bus.empty    = empty_r;
    assign bus.count    = count_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_sample_fifo.sv
// Directed self-checking bench for sample_fifo (WIDTH=8, DEPTH=16).
`timescale 1ns/1ps
module tb_sample_fifo;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    sample_fifo_if #(.WIDTH(8), .DEPTH(16)) bus_if ();

    sample_fifo #(.WIDTH(8), .DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_data = d;
        cyc();
        bus_if.wr_en   = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        bus_if.rd_en = 1'b1;
        cyc();
        bus_if.rd_en = 1'b0;
        check({tag, " rd_valid"}, {31'd0, bus_if.rd_valid}, 32'd1);
        check({tag, " rd_data"}, {24'd0, bus_if.rd_data}, {24'd0, exp});
    endtask

    task automatic reset_vals(input string tag);
        check({tag, " rd_data"},  {24'd0, bus_if.rd_data},  32'd0);
        check({tag, " rd_valid"}, {31'd0, bus_if.rd_valid}, 32'd0);
        check({tag, " count"},    {27'd0, bus_if.count},    32'd0);
        check({tag, " overflow"}, {31'd0, bus_if.overflow}, 32'd0);
        check({tag, " empty"},    {31'd0, bus_if.empty},    32'd1);
        check({tag, " full"},     {31'd0, bus_if.full},     32'd0);
        check({tag, " wr_ready"}, {31'd0, bus_if.wr_ready}, 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n            = 1'b0;
        bus_if.clr       = 1'b0;
        bus_if.ring_mode = 1'b0;
        bus_if.wr_en     = 1'b0;
        bus_if.wr_data   = 8'h00;
        bus_if.rd_en     = 1'b0;
        cyc();
        cyc();
        reset_vals("reset");
        rst_n = 1'b1;
        cyc();

        // Fill and drain
        for (int i = 0; i < 16; i++) push(8'(i));
        check("fill full",     {31'd0, bus_if.full},     32'd1);
        check("fill count",    {27'd0, bus_if.count},    32'd16);
        check("fill wr_ready", {31'd0, bus_if.wr_ready}, 32'd0);
        for (int i = 0; i < 16; i++) pop_chk($sformatf("drain%0d", i), 8'(i));
        check("drain empty", {31'd0, bus_if.empty}, 32'd1);
        cyc();
        check("drain rd_valid pulse", {31'd0, bus_if.rd_valid}, 32'd0);

        // Drop on full
        for (int i = 0; i < 16; i++) push(8'(i));
        push(8'hAA);
        check("drop overflow", {31'd0, bus_if.overflow}, 32'd1);
        check("drop count",    {27'd0, bus_if.count},    32'd16);
        for (int i = 0; i < 16; i++) pop_chk($sformatf("drop drain%0d", i), 8'(i));
        check("drop empty",  {31'd0, bus_if.empty},    32'd1);
        check("drop sticky", {31'd0, bus_if.overflow}, 32'd1);
        bus_if.clr = 1'b1;
        cyc();
        bus_if.clr = 1'b0;
        check("clr overflow", {31'd0, bus_if.overflow}, 32'd0);

        // Ring overwrite
        bus_if.ring_mode = 1'b1;
        for (int i = 0; i < 20; i++) push(8'(i));
        check("ring count",    {27'd0, bus_if.count},    32'd16);
        check("ring overflow", {31'd0, bus_if.overflow}, 32'd1);
        check("ring wr_ready", {31'd0, bus_if.wr_ready}, 32'd1);
        for (int i = 4; i < 20; i++) pop_chk($sformatf("ring drain%0d", i), 8'(i));
        check("ring empty", {31'd0, bus_if.empty}, 32'd1);
        bus_if.ring_mode = 1'b0;
        bus_if.clr = 1'b1;
        cyc();
        bus_if.clr = 1'b0;

        // Simultaneous read and write at full
        for (int i = 0; i < 16; i++) push(8'(i));
        bus_if.wr_en   = 1'b1;
        bus_if.wr_data = 8'h55;
        bus_if.rd_en   = 1'b1;
        cyc();
        bus_if.wr_en = 1'b0;
        bus_if.rd_en = 1'b0;
        check("simul full count",    {27'd0, bus_if.count},    32'd16);
        check("simul full rd_data",  {24'd0, bus_if.rd_data},  32'h00);
        check("simul full rd_valid", {31'd0, bus_if.rd_valid}, 32'd1);
        check("simul full overflow", {31'd0, bus_if.overflow}, 32'd0);
        for (int i = 1; i < 16; i++) pop_chk($sformatf("simul drain%0d", i), 8'(i));
        pop_chk("simul drain new", 8'h55);

        // Simultaneous read and write at count 1
        push(8'h11);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_data = 8'h22;
        bus_if.rd_en   = 1'b1;
        cyc();
        bus_if.wr_en = 1'b0;
        bus_if.rd_en = 1'b0;
        check("simul one count",   {27'd0, bus_if.count},   32'd1);
        check("simul one rd_data", {24'd0, bus_if.rd_data}, 32'h11);
        pop_chk("simul one next", 8'h22);

        // Empty read is ignored
        bus_if.rd_en = 1'b1;
        cyc();
        bus_if.rd_en = 1'b0;
        check("empty rd_valid", {31'd0, bus_if.rd_valid}, 32'd0);
        check("empty rd_data",  {24'd0, bus_if.rd_data},  32'h22);
        check("empty count",    {27'd0, bus_if.count},    32'd0);

        // clr beats a concurrent write and read
        for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
        check("pre-clr count", {27'd0, bus_if.count}, 32'd5);
        bus_if.clr     = 1'b1;
        bus_if.wr_en   = 1'b1;
        bus_if.wr_data = 8'h77;
        bus_if.rd_en   = 1'b1;
        cyc();
        bus_if.clr   = 1'b0;
        bus_if.wr_en = 1'b0;
        bus_if.rd_en = 1'b0;
        check("clr count",    {27'd0, bus_if.count},    32'd0);
        check("clr empty",    {31'd0, bus_if.empty},    32'd1);
        check("clr overflow", {31'd0, bus_if.overflow}, 32'd0);
        check("clr rd_valid", {31'd0, bus_if.rd_valid}, 32'd0);
        check("clr rd_data",  {24'd0, bus_if.rd_data},  32'h22);
        push(8'h40);
        pop_chk("post-clr", 8'h40);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
        pop_chk("pre-rst", 8'h60);
        check("pre-rst count", {27'd0, bus_if.count}, 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        reset_vals("async rst");
        cyc();
        rst_n = 1'b1;
        cyc();
        push(8'h99);
        check("post-rst count", {27'd0, bus_if.count}, 32'd1);
        pop_chk("post-rst", 8'h99);
        check("post-rst empty", {31'd0, bus_if.empty}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_fifo.md
# sample_fifo

Parametrised sample buffer between the capture/trigger logic and the readout interface of the logic analyzer. It stores WIDTH-bit samples in a DEPTH-entry circular buffer and delivers them with a registered read port. Simultaneous read and write are well-defined, and full, empty, occupancy and sticky overflow status are exposed. A ring mode overwrites the oldest sample when full, so pre-trigger history can be held until the trigger fires.

## Interface
- WIDTH, 8, sample width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AW, $clog2(DEPTH), pointer width (derived, not overridden)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush
- ring_mode  in  1  1 = overwrite oldest when full; 0 = drop when full
- wr_en  in  1  write request
- wr_data  in  WIDTH  sample to write
- wr_ready  out  1  combinational: !full | ring_mode
- rd_en  in  1  read request
- rd_data  out  WIDTH  registered read data
- rd_valid  out  1  rd_data updated this cycle (single-cycle pulse)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  AW+1  occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was dropped, or an old sample was overwritten

## Operation
- Write accepted: wr_en & (!full | rd_accept | ring_mode). Entry goes to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Read accepted (rd_accept): rd_en & !empty. rd_data <= mem[rd_ptr]; rd_ptr increments; rd_valid <= 1.
- count update: +1 for write only, −1 for read only, unchanged for both or neither. A single unified update is required; separate, competing assignments are not allowed.
- Full, non-ring, wr_en, no read: write dropped, all state unchanged, overflow <= 1.
- Full, ring_mode, wr_en, no read: write accepted, rd_ptr also increments (oldest discarded), count stays DEPTH, overflow <= 1.
- Full, wr_en and rd_en together: both accepted normally. rd_data returns the oldest entry; no overflow.
- Empty, rd_en: ignored; rd_valid stays 0 and rd_data holds. No write-to-read bypass: a write to an empty FIFO is readable from the next cycle.
- clr: pointers, count, overflow and rd_valid go to 0. clr overrides any write or read in the same cycle. rd_data holds. Memory contents are not cleared.
- overflow clears only on clr or reset.
- ring_mode may change at any time; it takes effect in the same cycle.

## Timing
- Reset values: rd_data = 0, rd_valid = 0, count = 0, overflow = 0, empty = 1, full = 0, wr_ready = 1. Pointers are 0.
- Read latency is 1 cycle: a read accepted at edge N gives rd_data/rd_valid valid after edge N, for one cycle.
- full, empty and count are registered-state derived and reflect accepted operations one cycle after the edge.
- Wrap-around: pointers are AW bits and roll over DEPTH−1 → 0 naturally. count is AW+1 bits so that DEPTH is representable.
- Reset asserted mid-operation clears all state immediately (asynchronous). Deassertion is synchronous to clk, supplied upstream.

## Structure
- Shared package la_pkg holds SAMPLE_W_DEFAULT (8) and FIFO_DEPTH_DEFAULT (16), used by the capture and readout blocks.
- One sub-module: sample_fifo_mem, a simple dual-port register array (WIDTH × DEPTH) with synchronous write and synchronous read-register. Control, pointers and flags live in sample_fifo.

## Test plan
- Fill/drain, DEPTH=16: write 0x00..0x0F → full=1, count=16. Read 16 times → rd_data 0x00..0x0F in order, each with rd_valid 1 cycle after rd_en; then empty=1.
- Drop on full (ring_mode=0): fill 16, then write 0xAA → overflow=1, count=16. Drain returns 0x00..0x0F; 0xAA is never seen.
- Ring overwrite (ring_mode=1): write 0x00..0x13 (20 samples) → count=16, overflow=1. Drain returns 0x04..0x13.
- Simultaneous access: at full, wr_en+rd_en with 0x55 → count stays 16, rd_data=0x00, overflow=0. At count=1, wr+rd → count stays 1, next read gives the new value.
- Empty read / clr priority: rd_en on empty → rd_valid=0, rd_data unchanged. clr with wr_en at count=5 → count=0, empty=1, overflow=0, written value discarded.
- Async reset mid-stream: assert rst_n=0 between edges with count=7 → outputs reach reset values immediately. After release, a 1-write/1-read sequence works correctly.
